// File: rtl/wbu_pkg.sv
// Shared types for the writeback/commit stage: CSR slot map and FSM states.
package wbu_pkg;

    localparam int unsigned RETIRE_W = 64;

    typedef enum logic [1:0] {
        CSR_MCAUSE  = 2'd0,
        CSR_MEPC    = 2'd1,
        CSR_MSTATUS = 2'd2,
        CSR_MTVEC   = 2'd3
    } csr_idx_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } wbu_state_e;

endpackage

// File: rtl/wbu_commit_if.sv
// Retire handshake, IDU read ports and commit trace of the writeback stage.
interface wbu_commit_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NCSR = 4,
    parameter int unsigned NRD  = 2
);
    import wbu_pkg::*;

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned CW = $clog2(NCSR);

    logic                 in_valid;
    logic                 in_ready;
    logic [RW-1:0]        in_rd;
    logic [XLEN-1:0]      in_wd;
    logic                 in_reg_we;
    logic [CW-1:0]        in_csr_rd;
    logic [XLEN-1:0]      in_csr_wd;
    logic                 in_csr_we;
    logic                 in_ecall;
    logic                 in_ebreak;
    logic [XLEN-1:0]      in_pc;
    logic [XLEN-1:0]      in_pc_next;
    logic [XLEN-1:0]      in_instr;

    logic [NRD*RW-1:0]    rs_idx;
    logic [NRD*XLEN-1:0]  rs_data;
    logic [CW-1:0]        csr_rs;
    logic [XLEN-1:0]      csr_rdata;

    logic                 cmt_valid;
    logic [XLEN-1:0]      cmt_pc;
    logic [XLEN-1:0]      cmt_pc_next;
    logic [XLEN-1:0]      cmt_instr;
    logic [RETIRE_W-1:0]  retire_cnt;
    logic                 halted;

    modport master (
        output in_valid, in_rd, in_wd, in_reg_we, in_csr_rd, in_csr_wd, in_csr_we,
               in_ecall, in_ebreak, in_pc, in_pc_next, in_instr, rs_idx, csr_rs,
        input  in_ready, rs_data, csr_rdata, cmt_valid, cmt_pc, cmt_pc_next,
               cmt_instr, retire_cnt, halted
    );

    modport slave (
        input  in_valid, in_rd, in_wd, in_reg_we, in_csr_rd, in_csr_wd, in_csr_we,
               in_ecall, in_ebreak, in_pc, in_pc_next, in_instr, rs_idx, csr_rs,
        output in_ready, rs_data, csr_rdata, cmt_valid, cmt_pc, cmt_pc_next,
               cmt_instr, retire_cnt, halted
    );

endinterface

// File: rtl/wbu_commit_gpr_bank.sv
// GPR storage with hard-wired x0, NRD combinational read ports and optional write bypass.
module gpr_bank #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned NRD     = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned SRC_IDX = 15,
    localparam int unsigned RW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [RW-1:0]       i_rd,
    input  logic [XLEN-1:0]     i_wd,
    input  logic [NRD*RW-1:0]   i_rs_idx,
    output logic [NRD*XLEN-1:0] o_rs_data,
    output logic [XLEN-1:0]     o_src_data
);

    logic [XLEN-1:0] r_x [NREG];
    logic [RW-1:0]   w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_x[i] <= '0;
        end else if (i_we && i_rd != '0) begin
            r_x[i_rd] <= i_wd;
        end
    end

    // x0 never holds data; bypass forwards the write being accepted this cycle
    always_comb begin
        o_rs_data = '0;
        w_idx     = '0;
        for (int k = 0; k < NRD; k++) begin
            w_idx = i_rs_idx[k*RW +: RW];
            if (w_idx != '0) begin
                if (BYPASS != 0 && i_we && i_rd == w_idx) o_rs_data[k*XLEN +: XLEN] = i_wd;
                else                                      o_rs_data[k*XLEN +: XLEN] = r_x[w_idx];
            end
        end
    end

    // Pre-write register value, used for ecall cause capture
    assign o_src_data = r_x[RW'(SRC_IDX)];

endmodule

// File: rtl/wbu_commit.sv
// Writeback/commit stage: retire handshake, halt FSM, CSR file, ecall capture, trace and retire count.
module wbu_commit
    import wbu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned NCSR      = 4,
    parameter int unsigned NRD       = 2,
    parameter int unsigned ECALL_SRC = 15,
    parameter int unsigned BYPASS    = 1
) (
    input  logic         clk,
    input  logic         rst,
    wbu_commit_if.slave  bus
);

    localparam int unsigned CW       = $clog2(NCSR);
    localparam bit          CSR_FULL = (NCSR == (32'd1 << CW));

    wbu_state_e           r_state, w_state_nxt;
    logic                 w_acc;
    logic                 w_csr_wok, w_csr_rok;
    logic [XLEN-1:0]      w_src;
    logic [XLEN-1:0]      r_csr [NCSR];
    logic                 r_cmt_valid;
    logic [XLEN-1:0]      r_cmt_pc, r_cmt_pc_next, r_cmt_instr;
    logic [RETIRE_W-1:0]  r_retire_cnt;

    assign bus.in_ready = (r_state == RUN);
    assign bus.halted   = (r_state == HALT);
    assign w_acc        = bus.in_valid && (r_state == RUN);

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // HALT is terminal until reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_acc && bus.in_ebreak) w_state_nxt = HALT;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = RUN;
        endcase
    end

    gpr_bank #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(BYPASS), .SRC_IDX(ECALL_SRC)
    ) u_gpr (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_acc && bus.in_reg_we),
        .i_rd       (bus.in_rd),
        .i_wd       (bus.in_wd),
        .i_rs_idx   (bus.rs_idx),
        .o_rs_data  (bus.rs_data),
        .o_src_data (w_src)
    );

    // Slot indices past NCSR only exist when NCSR is not a power of two
    if (CSR_FULL) begin : g_csr_full
        assign w_csr_wok = 1'b1;
        assign w_csr_rok = 1'b1;
    end else begin : g_csr_part
        assign w_csr_wok = (32'(bus.in_csr_rd) < NCSR);
        assign w_csr_rok = (32'(bus.csr_rs) < NCSR);
    end

    // ecall writes are placed last so they win over a same-cycle CSR write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCSR; i++) r_csr[i] <= '0;
        end else if (w_acc) begin
            if (bus.in_csr_we && w_csr_wok) r_csr[bus.in_csr_rd] <= bus.in_csr_wd;
            if (bus.in_ecall) begin
                r_csr[int'(CSR_MCAUSE)] <= w_src;
                r_csr[int'(CSR_MEPC)]   <= bus.in_pc;
            end
        end
    end

    assign bus.csr_rdata = w_csr_rok ? r_csr[bus.csr_rs] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmt_valid   <= 1'b0;
            r_cmt_pc      <= '0;
            r_cmt_pc_next <= '0;
            r_cmt_instr   <= '0;
            r_retire_cnt  <= '0;
        end else begin
            r_cmt_valid <= w_acc;
            if (w_acc) begin
                r_cmt_pc      <= bus.in_pc;
                r_cmt_pc_next <= bus.in_pc_next;
                r_cmt_instr   <= bus.in_instr;
                r_retire_cnt  <= r_retire_cnt + RETIRE_W'(1);
            end
        end
    end

    assign bus.cmt_valid   = r_cmt_valid;
    assign bus.cmt_pc      = r_cmt_pc;
    assign bus.cmt_pc_next = r_cmt_pc_next;
    assign bus.cmt_instr   = r_cmt_instr;
    assign bus.retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_wbu_commit.sv
// Directed plus random checks of wbu_commit against an architectural model of the stage.
module tb_wbu_commit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wbu_commit_if #(.NREG(32)) bus ();
    wbu_commit_if #(.NREG(16)) bus16 ();

    wbu_commit #(.NREG(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
    wbu_commit #(.NREG(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural model
    logic [31:0] m_x [32];
    logic [31:0] m_csr [4];
    logic [63:0] m_cnt;
    logic        m_cv, m_halt;
    logic [31:0] m_pc, m_pcn, m_ins;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = '0;
        for (int i = 0; i < 4; i++) m_csr[i] = '0;
        m_cnt = '0; m_cv = 1'b0; m_halt = 1'b0;
        m_pc = '0; m_pcn = '0; m_ins = '0;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_rd = '0; bus.in_wd = '0; bus.in_reg_we = 0;
        bus.in_csr_rd = '0; bus.in_csr_wd = '0; bus.in_csr_we = 0;
        bus.in_ecall = 0; bus.in_ebreak = 0; bus.in_pc = '0; bus.in_pc_next = '0;
        bus.in_instr = '0; bus.rs_idx = '0; bus.csr_rs = '0;
    endtask

    task automatic check_seq();
        chk("cmt_valid",   64'(bus.cmt_valid),   64'(m_cv));
        chk("cmt_pc",      64'(bus.cmt_pc),      64'(m_pc));
        chk("cmt_pc_next", 64'(bus.cmt_pc_next), 64'(m_pcn));
        chk("cmt_instr",   64'(bus.cmt_instr),   64'(m_ins));
        chk("retire_cnt",  bus.retire_cnt,       m_cnt);
        chk("halted",      64'(bus.halted),      64'(m_halt));
    endtask

    // One clock: check combinational outputs, advance model on accept, check registered outputs
    task automatic cycle();
        logic        acc;
        logic [4:0]  idx;
        logic [31:0] exp, src;
        #1;
        acc = bus.in_valid && !m_halt;
        chk("in_ready", 64'(bus.in_ready), 64'(!m_halt));
        for (int k = 0; k < 2; k++) begin
            idx = bus.rs_idx[k*5 +: 5];
            if (idx == 0) exp = '0;
            else if (acc && bus.in_reg_we && bus.in_rd == idx) exp = bus.in_wd;
            else exp = m_x[idx];
            chk($sformatf("rs_data%0d[x%0d]", k, idx), 64'(bus.rs_data[k*32 +: 32]), 64'(exp));
        end
        chk("csr_rdata", 64'(bus.csr_rdata), 64'(m_csr[bus.csr_rs]));
        @(posedge clk);
        if (acc) begin
            src = m_x[15];
            if (bus.in_reg_we && bus.in_rd != 0) m_x[bus.in_rd] = bus.in_wd;
            if (bus.in_csr_we) m_csr[bus.in_csr_rd] = bus.in_csr_wd;
            if (bus.in_ecall) begin m_csr[0] = src; m_csr[1] = bus.in_pc; end
            m_cnt = m_cnt + 64'd1;
            m_pc = bus.in_pc; m_pcn = bus.in_pc_next; m_ins = bus.in_instr;
            if (bus.in_ebreak) m_halt = 1'b1;
        end
        m_cv = acc;
        @(negedge clk);
        check_seq();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_seq();
        chk("in_ready_rst", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic write(input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] pc);
        idle_inputs();
        bus.in_valid = 1; bus.in_reg_we = 1; bus.in_rd = rd; bus.in_wd = wd;
        bus.in_pc = pc; bus.in_pc_next = pc + 32'd4; bus.in_instr = 32'h0000_0013 ^ pc;
        bus.rs_idx = {5'd0, rd};
    endtask

    initial begin
        idle_inputs();
        bus16.in_valid = 0; bus16.in_rd = '0; bus16.in_wd = '0; bus16.in_reg_we = 0;
        bus16.in_csr_rd = '0; bus16.in_csr_wd = '0; bus16.in_csr_we = 0;
        bus16.in_ecall = 0; bus16.in_ebreak = 0; bus16.in_pc = '0; bus16.in_pc_next = '0;
        bus16.in_instr = '0; bus16.rs_idx = '0; bus16.csr_rs = '0;
        do_reset();

        // x5 write with same-cycle bypass, then registered read
        write(5'd5, 32'hDEAD_BEEF, 32'h8000_0000);
        #1 chk("x5_bypass", 64'(bus.rs_data[31:0]), 64'h0000_0000_DEAD_BEEF);
        cycle();
        idle_inputs(); bus.rs_idx = {5'd0, 5'd5};
        #1 chk("x5_next", 64'(bus.rs_data[31:0]), 64'h0000_0000_DEAD_BEEF);
        cycle();

        // x0 write dropped, still retires once
        write(5'd0, 32'h0000_1234, 32'h8000_0004);
        cycle();
        chk("retire_after_x0", bus.retire_cnt, 64'd2);
        idle_inputs();
        #1 chk("x0_zero", 64'(bus.rs_data[31:0]), 64'd0);
        cycle();

        // ecall captures pre-write x15 and pc over a same-cycle mepc write
        write(5'd15, 32'h0000_000B, 32'h8000_0008);
        cycle();
        write(5'd15, 32'h0000_0077, 32'h8000_0010);
        bus.in_ecall = 1; bus.in_csr_we = 1; bus.in_csr_rd = 2'd1; bus.in_csr_wd = 32'h55;
        cycle();
        idle_inputs(); bus.csr_rs = 2'd0;
        #1 chk("mcause", 64'(bus.csr_rdata), 64'h0B);
        bus.csr_rs = 2'd1;
        #1 chk("mepc", 64'(bus.csr_rdata), 64'h8000_0010);
        cycle();

        // Randomized traffic, no ebreak
        for (int n = 0; n < 300; n++) begin
            idle_inputs();
            bus.in_valid   = ($urandom_range(3) != 0);
            bus.in_rd      = 5'($urandom);
            bus.in_wd      = $urandom;
            bus.in_reg_we  = ($urandom_range(3) != 0);
            bus.in_csr_rd  = 2'($urandom);
            bus.in_csr_wd  = $urandom;
            bus.in_csr_we  = ($urandom_range(3) == 0);
            bus.in_ecall   = ($urandom_range(7) == 0);
            bus.in_pc      = $urandom;
            bus.in_pc_next = $urandom;
            bus.in_instr   = $urandom;
            bus.rs_idx     = {($urandom_range(1) != 0) ? bus.in_rd : 5'($urandom), 5'($urandom)};
            bus.csr_rs     = 2'($urandom);
            cycle();
        end

        // Retire counter wrap
        force dut.r_retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.r_retire_cnt;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        write(5'd7, 32'h1111_2222, 32'h8000_0014);
        cycle();
        write(5'd8, 32'h3333_4444, 32'h8000_0018);
        cycle();
        chk("retire_wrap", bus.retire_cnt, 64'd1);

        // ebreak commits then freezes the stage
        write(5'd9, 32'hCAFE_F00D, 32'h8000_0020);
        bus.in_ebreak = 1;
        cycle();
        chk("ebreak_pc", 64'(bus.cmt_pc), 64'h8000_0020);
        chk("ebreak_halted", 64'(bus.halted), 64'd1);
        chk("ebreak_ready", 64'(bus.in_ready), 64'd0);
        for (int n = 0; n < 3; n++) begin
            write(5'd6, 32'hBAD0_0000 + 32'(n), 32'h8000_0024);
            bus.in_csr_we = 1; bus.in_csr_wd = 32'hFFFF_FFFF;
            cycle();
        end
        chk("halt_cnt_frozen", bus.retire_cnt, 64'd2);

        // Reset while halted with a pending instruction
        write(5'd6, 32'h0BAD_0BAD, 32'h8000_0028);
        do_reset();
        idle_inputs(); bus.rs_idx = {5'd9, 5'd5};
        cycle();

        // Reset while running discards the concurrent accept
        write(5'd3, 32'h0000_0003, 32'h8000_0030);
        cycle();
        write(5'd4, 32'h0000_0004, 32'h8000_0034);
        do_reset();
        idle_inputs(); bus.rs_idx = {5'd4, 5'd3};
        cycle();

        // RV32E configuration: x15 is the top register
        bus16.in_valid = 1; bus16.in_reg_we = 1; bus16.in_rd = 4'd15; bus16.in_wd = 32'hA5A5_0F0F;
        bus16.rs_idx = {4'd0, 4'd15};
        #1 chk("e_x15_bypass", 64'(bus16.rs_data[31:0]), 64'hA5A5_0F0F);
        @(negedge clk);
        bus16.in_rd = 4'd0; bus16.in_wd = 32'h1234;
        bus16.rs_idx = {4'd0, 4'd15};
        #1 chk("e_x15_read", 64'(bus16.rs_data[31:0]), 64'hA5A5_0F0F);
        @(negedge clk);
        bus16.in_valid = 0; bus16.rs_idx = {4'd15, 4'd0};
        #1 chk("e_x0_read", 64'(bus16.rs_data[31:0]), 64'd0);
        chk("e_x15_port1", 64'(bus16.rs_data[63:32]), 64'hA5A5_0F0F);
        chk("e_retire", bus16.retire_cnt, 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
